// File: rtl/alu_share_ctrl.sv
// Round-robin controller that time-shares one external combinational ALU
// between two requesters and returns each result over a valid/ready channel.
module alu_share_ctrl #(
    parameter int W       = 32,
    parameter int ALU_LAT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic [2:0]   req0_op,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    input  logic [2:0]   req1_op,
    output logic         rsp0_valid,
    input  logic         rsp0_ready,
    output logic [W-1:0] rsp0_res,
    output logic         rsp0_cout,
    output logic         rsp0_err,
    output logic         rsp1_valid,
    input  logic         rsp1_ready,
    output logic [W-1:0] rsp1_res,
    output logic         rsp1_cout,
    output logic         rsp1_err,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [2:0]   alu_op,
    output logic         alu_c0,
    input  logic [W-1:0] alu_res,
    input  logic         alu_cout,
    output logic         busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [3:0] CNT_INIT = 4'(ALU_LAT - 1);

    state_t         state_q, state_d;
    logic           ptr_q, ptr_d;
    logic           win_q, win_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [W-1:0]   alu_a_q, alu_a_d;
    logic [W-1:0]   alu_b_q, alu_b_d;
    logic [2:0]     alu_op_q, alu_op_d;
    logic           alu_c0_q, alu_c0_d;
    logic [W-1:0]   res_q, res_d;
    logic           cout_q, cout_d;
    logic           err_q, err_d;

    logic           grant0, grant1;
    logic [W-1:0]   sel_a, sel_b;
    logic [2:0]     sel_op;
    logic           sel_legal;

    // The pointer side wins a tie; a lone valid requester always wins.
    assign grant0 = req0_valid && (!ptr_q || !req1_valid);
    assign grant1 = req1_valid && (ptr_q || !req0_valid);
    assign sel_a  = grant1 ? req1_a  : req0_a;
    assign sel_b  = grant1 ? req1_b  : req0_b;
    assign sel_op = grant1 ? req1_op : req0_op;

    always_comb begin
        case (sel_op)
            3'b000, 3'b001, 3'b010, 3'b110, 3'b111: sel_legal = 1'b1;
            default:                                sel_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        win_d    = win_q;
        cnt_d    = cnt_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        alu_op_d = alu_op_q;
        alu_c0_d = alu_c0_q;
        res_d    = res_q;
        cout_d   = cout_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (grant0 || grant1) begin
                    win_d = grant1;
                    ptr_d = ~grant1;
                    if (sel_legal) begin
                        alu_a_d  = sel_a;
                        alu_b_d  = sel_b;
                        alu_op_d = sel_op;
                        alu_c0_d = sel_op[2];
                        cnt_d    = CNT_INIT;
                        state_d  = EXEC;
                    end else begin
                        // Illegal op bypasses the ALU so its inputs stay untouched.
                        res_d   = '0;
                        cout_d  = 1'b0;
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            EXEC: begin
                if (cnt_q == 4'd0) begin
                    res_d   = alu_res;
                    cout_d  = alu_cout && alu_op_q[1];
                    err_d   = 1'b0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (win_q ? rsp1_ready : rsp0_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ptr_q    <= 1'b0;
            win_q    <= 1'b0;
            cnt_q    <= 4'd0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= 3'b000;
            alu_c0_q <= 1'b0;
            res_q    <= '0;
            cout_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            win_q    <= win_d;
            cnt_q    <= cnt_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            alu_op_q <= alu_op_d;
            alu_c0_q <= alu_c0_d;
            res_q    <= res_d;
            cout_q   <= cout_d;
            err_q    <= err_d;
        end
    end

    assign req0_ready = (state_q == IDLE) && grant0;
    assign req1_ready = (state_q == IDLE) && grant1;
    assign rsp0_valid = (state_q == RESP) && !win_q;
    assign rsp1_valid = (state_q == RESP) && win_q;
    assign rsp0_res   = res_q;
    assign rsp1_res   = res_q;
    assign rsp0_cout  = cout_q;
    assign rsp1_cout  = cout_q;
    assign rsp0_err   = err_q;
    assign rsp1_err   = err_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_op     = alu_op_q;
    assign alu_c0     = alu_c0_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: transaction-level model checked every cycle,
// directed literal cases, randomized traffic, and an ALU_LAT=4 reset case.
module tb_alu_share_ctrl;
    localparam int LAT1 = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]  req0_op, req1_op;
    logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
    logic [31:0] rsp0_res, rsp1_res;
    logic        rsp0_cout, rsp1_cout, rsp0_err, rsp1_err;
    logic [31:0] alu_a, alu_b, alu_res;
    logic [2:0]  alu_op;
    logic        alu_c0, alu_cout, busy;

    logic        d4_rst_n;
    logic        d4_req0_valid, d4_req1_valid, d4_req0_ready, d4_req1_ready;
    logic [31:0] d4_req0_a, d4_req0_b;
    logic [2:0]  d4_req0_op;
    logic        d4_rsp0_valid, d4_rsp1_valid;
    logic [31:0] d4_rsp0_res, d4_rsp1_res;
    logic        d4_rsp0_cout, d4_rsp1_cout, d4_rsp0_err, d4_rsp1_err;
    logic [31:0] d4_alu_a, d4_alu_b, d4_alu_res;
    logic [2:0]  d4_alu_op;
    logic        d4_alu_c0, d4_alu_cout, d4_busy;

    alu_share_ctrl #(.W(32), .ALU_LAT(LAT1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_res(rsp0_res), .rsp0_cout(rsp0_cout), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_res(rsp1_res), .rsp1_cout(rsp1_cout), .rsp1_err(rsp1_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c0(alu_c0),
        .alu_res(alu_res), .alu_cout(alu_cout), .busy(busy)
    );

    alu_share_ctrl #(.W(32), .ALU_LAT(4)) dut4 (
        .clk(clk), .rst_n(d4_rst_n),
        .req0_valid(d4_req0_valid), .req0_ready(d4_req0_ready), .req0_a(d4_req0_a), .req0_b(d4_req0_b), .req0_op(d4_req0_op),
        .req1_valid(d4_req1_valid), .req1_ready(d4_req1_ready), .req1_a(32'd3), .req1_b(32'd4), .req1_op(3'b010),
        .rsp0_valid(d4_rsp0_valid), .rsp0_ready(1'b1), .rsp0_res(d4_rsp0_res), .rsp0_cout(d4_rsp0_cout), .rsp0_err(d4_rsp0_err),
        .rsp1_valid(d4_rsp1_valid), .rsp1_ready(1'b1), .rsp1_res(d4_rsp1_res), .rsp1_cout(d4_rsp1_cout), .rsp1_err(d4_rsp1_err),
        .alu_a(d4_alu_a), .alu_b(d4_alu_b), .alu_op(d4_alu_op), .alu_c0(d4_alu_c0),
        .alu_res(d4_alu_res), .alu_cout(d4_alu_cout), .busy(d4_busy)
    );

    // External ALU: B is inverted for SUB/SLT, carry-in comes from the controller.
    function automatic logic [32:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] op, input logic c0);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, (op[2] ? ~b : b)} + {32'b0, c0};
        case (op)
            3'b000:         return {1'b0, a & b};
            3'b001:         return {1'b0, a | b};
            3'b010, 3'b110: return s;
            3'b111:         return {s[32], 31'b0, s[31]};
            default:        return 33'b0;
        endcase
    endfunction

    assign {alu_cout, alu_res}       = alu_fn(alu_a, alu_b, alu_op, alu_c0);
    assign {d4_alu_cout, d4_alu_res} = alu_fn(d4_alu_a, d4_alu_b, d4_alu_op, d4_alu_c0);

    // Expected response {err, cout, res} straight from the operation definitions.
    function automatic logic [33:0] exp_rsp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] wide;
        logic [31:0] diff;
        wide = {1'b0, a} + {1'b0, b};
        diff = a - b;
        case (op)
            3'b000:  return {2'b00, a & b};
            3'b001:  return {2'b00, a | b};
            3'b010:  return {1'b0, wide};
            3'b110:  return {1'b0, a >= b, diff};
            3'b111:  return {1'b0, a >= b, 31'b0, diff[31]};
            default: return {1'b1, 33'b0};
        endcase
    endfunction

    int errors = 0;
    int checks = 0;

    function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
        end
    endfunction

    function automatic void timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got=timeout expected=event", name);
    endfunction

    function automatic logic rdy(input int n);
        return (n == 0) ? req0_ready : req1_ready;
    endfunction

    function automatic logic vld(input int n);
        return (n == 0) ? rsp0_valid : rsp1_valid;
    endfunction

    // Model of the LAT1 instance: one job in flight, visible from a given cycle on.
    int          cyc = 0;
    bit          m_busy;
    int          m_ptr, m_win, m_ready_at;
    logic [33:0] m_exp;
    logic [31:0] m_la, m_lb;
    logic [2:0]  m_lop;
    int          glog[$];

    initial begin
        logic e_r0, e_r1, in_rsp;
        logic [2:0]  s_op;
        logic [31:0] s_a, s_b;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_busy = 0; m_ptr = 0; m_win = 0; m_ready_at = 0;
                m_la = '0; m_lb = '0; m_lop = '0;
                chk("rst_alu_ab", {alu_a, alu_b}, 64'd0);
                chk("rst_alu_ctl", {alu_op, alu_c0}, 64'd0);
                chk("rst_rsp_res", {rsp0_res, rsp1_res}, 64'd0);
                chk("rst_flags", {rsp0_valid, rsp1_valid, rsp0_cout, rsp1_cout, rsp0_err, rsp1_err,
                                  req0_ready, req1_ready, busy}, 64'd0);
            end else begin
                e_r0   = !m_busy && req0_valid && (m_ptr == 0 || !req1_valid);
                e_r1   = !m_busy && req1_valid && (m_ptr == 1 || !req0_valid);
                in_rsp = m_busy && (cyc >= m_ready_at);
                chk("req_ready", {req0_ready, req1_ready}, {e_r0, e_r1});
                chk("busy", busy, m_busy);
                chk("rsp_valid", {rsp0_valid, rsp1_valid}, {in_rsp && m_win == 0, in_rsp && m_win == 1});
                chk("alu_drive", {alu_op, alu_c0, alu_a},
                    {m_lop, (m_lop == 3'b110 || m_lop == 3'b111), m_la});
                chk("alu_b", alu_b, m_lb);
                if (in_rsp && m_win == 0) chk("rsp0_data", {rsp0_err, rsp0_cout, rsp0_res}, m_exp);
                if (in_rsp && m_win == 1) chk("rsp1_data", {rsp1_err, rsp1_cout, rsp1_res}, m_exp);
                if (e_r0 || e_r1) begin
                    m_win = e_r1 ? 1 : 0;
                    s_op  = e_r1 ? req1_op : req0_op;
                    s_a   = e_r1 ? req1_a : req0_a;
                    s_b   = e_r1 ? req1_b : req0_b;
                    m_exp = exp_rsp(s_op, s_a, s_b);
                    m_ptr = 1 - m_win;
                    m_busy = 1;
                    m_ready_at = cyc + 1 + (m_exp[33] ? 0 : LAT1);
                    if (!m_exp[33]) begin
                        m_la = s_a; m_lb = s_b; m_lop = s_op;
                    end
                    glog.push_back(m_win);
                end else if (in_rsp && (m_win == 0 ? rsp0_ready : rsp1_ready)) begin
                    m_busy = 0;
                end
            end
            cyc++;
        end
    end

    task automatic drive(input int n, input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (n == 0) begin
            req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
        end else begin
            req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
        end
    endtask

    // One request on port n with its response ready already high; lat counts negedges after accept.
    task automatic do_req(input int n, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic cout, output logic err, output int lat);
        int t;
        res = '0; cout = 1'b0; err = 1'b0; lat = 0;
        drive(n, 1'b1, op, a, b);
        for (t = 0; t < 60; t++) begin
            @(negedge clk);
            if (rdy(n)) break;
        end
        if (t == 60) begin
            timeout("accept_wait");
            drive(n, 1'b0, op, a, b);
            return;
        end
        @(posedge clk); #1;
        drive(n, 1'b0, op, a, b);
        for (lat = 1; lat < 60; lat++) begin
            @(negedge clk);
            if (vld(n)) break;
        end
        if (lat == 60) begin
            timeout("rsp_wait");
            return;
        end
        res  = (n == 0) ? rsp0_res  : rsp1_res;
        cout = (n == 0) ? rsp0_cout : rsp1_cout;
        err  = (n == 0) ? rsp0_err  : rsp1_err;
        @(posedge clk); #1;
    endtask

    bit rnd_on;

    task automatic rand_req(input int n, input int count);
        int hold;
        bit acc;
        logic [31:0] a, b;
        for (int k = 0; k < count; k++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            a = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'd1 : $urandom;
            drive(n, 1'b1, 3'($urandom_range(0, 7)), a, b);
            hold = $urandom_range(1, 12);
            acc  = 0;
            for (int t = 0; t < hold && !acc; t++) begin
                @(negedge clk);
                if (rdy(n)) acc = 1;
                @(posedge clk); #1;
            end
            drive(n, 1'b0, 3'b000, 32'd0, 32'd0);
        end
    endtask

    task automatic rand_ready();
        while (rnd_on) begin
            @(posedge clk); #1;
            rsp0_ready = 1'($urandom_range(0, 1));
            rsp1_ready = 1'($urandom_range(0, 1));
        end
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got=time_limit expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] r, ra, rb, xa0, xb0, xa1, xb1, sum0, sum1;
        logic        c, e, ca, ea, cb, eb;
        int          l, la, lb, t;
        bit          seen;

        rst_n = 1'b0; d4_rst_n = 1'b0;
        drive(0, 1'b0, 3'b000, 32'd0, 32'd0);
        drive(1, 1'b0, 3'b000, 32'd0, 32'd0);
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        d4_req0_valid = 1'b0; d4_req1_valid = 1'b0; d4_req0_a = '0; d4_req0_b = '0; d4_req0_op = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1; d4_rst_n = 1'b1;

        // Both requesters stream ADDs: grants must alternate starting at 0.
        glog.delete();
        fork
            begin
                for (int k = 0; k < 4; k++) begin
                    xa0 = $urandom; xb0 = $urandom; sum0 = xa0 + xb0;
                    do_req(0, 3'b010, xa0, xb0, ra, ca, ea, la);
                    chk("t3_req0_res", ra, sum0);
                end
            end
            begin
                for (int k = 0; k < 4; k++) begin
                    xa1 = $urandom; xb1 = $urandom; sum1 = xa1 + xb1;
                    do_req(1, 3'b010, xa1, xb1, rb, cb, eb, lb);
                    chk("t3_req1_res", rb, sum1);
                end
            end
        join
        chk("t3_grant_count", glog.size(), 8);
        foreach (glog[i]) chk("t3_grant_order", glog[i], i % 2);

        do_req(0, 3'b111, 32'd5, 32'd7, r, c, e, l);
        chk("t1_slt_res", r, 32'h1);
        chk("t1_slt_err", e, 0);
        chk("t1_latency", l, 2);
        chk("t1_alu_c0", alu_c0, 1);
        chk("t1_alu_op", alu_op, 3'b111);

        do_req(1, 3'b010, 32'hFFFF_FFFF, 32'd1, r, c, e, l);
        chk("t2_add_res", r, 32'h0);
        chk("t2_add_cout", c, 1);
        do_req(1, 3'b110, 32'd7, 32'd5, r, c, e, l);
        chk("t2_sub_res", r, 32'h2);
        chk("t2_sub_cout", c, 1);
        chk("t2_sub_c0", alu_c0, 1);
        do_req(1, 3'b001, 32'hF0, 32'h0F, r, c, e, l);
        chk("t2_or_res", r, 32'hFF);
        chk("t2_or_cout", c, 0);
        do_req(1, 3'b110, 32'd7, 32'd5, r, c, e, l);

        do_req(0, 3'b011, 32'd9, 32'd9, r, c, e, l);
        chk("t5_err", e, 1);
        chk("t5_res", {c, r}, 0);
        chk("t5_latency", l, 1);
        chk("t5_alu_op_kept", alu_op, 3'b110);
        chk("t5_alu_a_kept", alu_a, 32'd7);

        // Response back-pressure on port 0 while port 1 waits.
        rsp0_ready = 1'b0;
        drive(0, 1'b1, 3'b010, 32'd10, 32'd20);
        for (t = 0; t < 20; t++) begin
            @(negedge clk);
            if (req0_ready) break;
        end
        if (t == 20) timeout("t4_accept");
        @(posedge clk); #1;
        drive(0, 1'b0, 3'b010, 32'd10, 32'd20);
        drive(1, 1'b1, 3'b010, 32'd1, 32'd2);
        for (t = 0; t < 20; t++) begin
            @(negedge clk);
            if (rsp0_valid) break;
        end
        if (t == 20) timeout("t4_rsp");
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            chk("t4_hold_valid_res", {rsp0_valid, rsp0_res}, {1'b1, 32'd30});
            chk("t4_loser_ready", req1_ready, 0);
        end
        @(posedge clk); #1;
        rsp0_ready = 1'b1;
        @(negedge clk);
        chk("t4_valid_until_edge", rsp0_valid, 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t4_back_idle", {busy, rsp0_valid, req1_ready}, 3'b001);
        @(posedge clk); #1;
        drive(1, 1'b0, 3'b010, 32'd1, 32'd2);
        for (t = 0; t < 20; t++) begin
            @(negedge clk);
            if (rsp1_valid) break;
        end
        if (t == 20) timeout("t4_rsp1");
        chk("t4_req1_res", rsp1_res, 32'd3);
        @(posedge clk); #1;

        rnd_on = 1;
        fork
            begin
                fork
                    rand_req(0, 120);
                    rand_req(1, 120);
                join
                rnd_on = 0;
            end
            rand_ready();
        join
        for (t = 0; t < 100; t++) begin
            @(negedge clk);
            if (!busy) break;
        end
        if (t == 100) timeout("drain");

        // ALU_LAT=4 instance: reset during the second EXEC cycle.
        @(posedge clk); #1;
        d4_req0_valid = 1'b1; d4_req0_op = 3'b010; d4_req0_a = 32'd100; d4_req0_b = 32'd23;
        for (t = 0; t < 20; t++) begin
            @(negedge clk);
            if (d4_req0_ready) break;
        end
        if (t == 20) timeout("t6_accept");
        @(posedge clk); #1;
        d4_req0_valid = 1'b0;
        @(negedge clk);
        chk("t6_exec_busy", {d4_busy, d4_rsp0_valid}, 2'b10);
        @(posedge clk); #1;
        d4_rst_n = 1'b0;
        #1;
        chk("t6_rst_alu", {d4_alu_a, d4_alu_b}, 64'd0);
        chk("t6_rst_ctl", {d4_alu_op, d4_alu_c0, d4_rsp0_cout, d4_rsp1_cout, d4_rsp0_err, d4_rsp1_err}, 64'd0);
        chk("t6_rst_res", {d4_rsp0_res, d4_rsp1_res}, 64'd0);
        chk("t6_rst_flags", {d4_rsp0_valid, d4_rsp1_valid, d4_req0_ready, d4_req1_ready, d4_busy}, 64'd0);
        @(posedge clk); #1;
        d4_rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (d4_rsp0_valid || d4_rsp1_valid || d4_busy) seen = 1;
        end
        chk("t6_no_response", seen, 0);
        @(posedge clk); #1;
        d4_req0_valid = 1'b1; d4_req1_valid = 1'b1;
        @(negedge clk);
        chk("t6_ptr_reset", {d4_req0_ready, d4_req1_ready}, 2'b10);
        @(posedge clk); #1;
        d4_req0_valid = 1'b0; d4_req1_valid = 1'b0;
        for (l = 1; l < 30; l++) begin
            @(negedge clk);
            if (d4_rsp0_valid) break;
        end
        chk("t6_latency", l, 5);
        chk("t6_res", {d4_rsp0_err, d4_rsp0_cout, d4_rsp0_res}, {2'b00, 32'd123});
        @(posedge clk); #1;
        @(negedge clk);
        chk("t6_idle_after", d4_busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
